// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - state encoding and lamp codes for the intersection sequencer
package tl_pkg;

   typedef enum logic [2:0] {
      ST_NS_GREEN  = 3'd0,
      ST_NS_YELLOW = 3'd1,
      ST_ALL_RED_A = 3'd2,
      ST_EW_GREEN  = 3'd3,
      ST_EW_YELLOW = 3'd4,
      ST_ALL_RED_B = 3'd5,
      ST_PED_WALK  = 3'd6
   } tl_state_e;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable tick-enabled down-counter with zero flag
module phase_timer #(
   parameter int               CNT_W   = 8,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_tick,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic [CNT_W-1:0] o_count,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   // A load always wins: it happens on the expiring tick, which must not decrement.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= RST_VAL;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_tick && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - NS/EW phase sequencer; PED_WALK_EN adds a walk phase
module traffic_phase_ctrl
   import tl_pkg::*;
#(
   parameter int GREEN_TICKS  = 30,
   parameter int YELLOW_TICKS = 3,
   parameter int ALLRED_TICKS = 2,
   parameter int WALK_TICKS   = 10,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             ped_req,
   output logic [2:0]       ns_light,
   output logic [2:0]       ew_light,
   output logic             ped_walk,
   output logic [CNT_W-1:0] phase_left
);

   function automatic logic [CNT_W-1:0] phase_len_m1(input tl_state_e s);
      case (s)
         ST_NS_GREEN, ST_EW_GREEN:   phase_len_m1 = CNT_W'(GREEN_TICKS - 1);
         ST_NS_YELLOW, ST_EW_YELLOW: phase_len_m1 = CNT_W'(YELLOW_TICKS - 1);
         ST_PED_WALK:                phase_len_m1 = CNT_W'(WALK_TICKS - 1);
         default:                    phase_len_m1 = CNT_W'(ALLRED_TICKS - 1);
      endcase
   endfunction

   tl_state_e r_state;
   tl_state_e w_next;
   logic      w_zero;
   logic      w_expire;
   logic      w_go_walk;

   assign w_expire = tick & w_zero;

`ifdef PED_WALK_EN
   logic r_ped_pending;

   assign w_go_walk = r_ped_pending | ped_req;

   // Entering the walk consumes the request, even one arriving on that same tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ped_pending <= 1'b0;
      end else if (w_expire && (r_state == ST_ALL_RED_B) && w_go_walk) begin
         r_ped_pending <= 1'b0;
      end else if (ped_req && (r_state != ST_PED_WALK)) begin
         r_ped_pending <= 1'b1;
      end
   end

   assign ped_walk = (r_state == ST_PED_WALK);
`else
   logic w_unused_ped;

   assign w_go_walk    = 1'b0;
   assign w_unused_ped = ped_req;
   assign ped_walk     = 1'b0;
`endif

   always_comb begin
      w_next = ST_NS_GREEN;
      case (r_state)
         ST_NS_GREEN:  w_next = ST_NS_YELLOW;
         ST_NS_YELLOW: w_next = ST_ALL_RED_A;
         ST_ALL_RED_A: w_next = ST_EW_GREEN;
         ST_EW_GREEN:  w_next = ST_EW_YELLOW;
         ST_EW_YELLOW: w_next = ST_ALL_RED_B;
         ST_ALL_RED_B: w_next = w_go_walk ? ST_PED_WALK : ST_NS_GREEN;
         default:      w_next = ST_NS_GREEN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_ALL_RED_B;
      end else if (w_expire) begin
         r_state <= w_next;
      end
   end

   phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (CNT_W'(ALLRED_TICKS - 1))
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .i_tick     (tick),
      .i_load     (w_expire),
      .i_load_val (phase_len_m1(w_next)),
      .o_count    (phase_left),
      .o_zero     (w_zero)
   );

   // Lamps depend on the state register only, so they switch one clk after expiry.
   always_comb begin
      ns_light = LAMP_R;
      ew_light = LAMP_R;
      case (r_state)
         ST_NS_GREEN:  ns_light = LAMP_G;
         ST_NS_YELLOW: ns_light = LAMP_Y;
         ST_EW_GREEN:  ew_light = LAMP_G;
         ST_EW_YELLOW: ew_light = LAMP_Y;
         default: begin
            ns_light = LAMP_R;
            ew_light = LAMP_R;
         end
      endcase
   end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - self-checking bench with phase-list model for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

   localparam int G = 4, Y = 2, AR = 1, W = 3, CW = 8;
`ifdef PED_WALK_EN
   localparam bit PED = 1'b1;
`else
   localparam bit PED = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          tick = 1'b0;
   logic          ped_req = 1'b0;
   logic [2:0]    ns_light, ew_light;
   logic          ped_walk;
   logic [CW-1:0] phase_left;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   traffic_phase_ctrl #(
      .GREEN_TICKS (G), .YELLOW_TICKS (Y), .ALLRED_TICKS (AR),
      .WALK_TICKS (W), .CNT_W (CW)
   ) dut (
      .clk (clk), .reset (reset), .tick (tick), .ped_req (ped_req),
      .ns_light (ns_light), .ew_light (ew_light),
      .ped_walk (ped_walk), .phase_left (phase_left)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: phase index into the ring NS_G, NS_Y, AR_A, EW_G, EW_Y, AR_B (+6 = walk)
   int m_phase = 5;
   int m_elapsed = 0;
   bit m_pend = 1'b0;

   function automatic int plen(input int p);
      case (p)
         0, 3:    plen = G;
         1, 4:    plen = Y;
         6:       plen = W;
         default: plen = AR;
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase   <= 5;
         m_elapsed <= 0;
         m_pend    <= 1'b0;
      end else begin
         automatic int nph = m_phase;
         automatic int nel = m_elapsed;
         automatic bit walk_now = 1'b0;
         if (tick) begin
            if (m_elapsed == plen(m_phase) - 1) begin
               nel = 0;
               if (m_phase == 5) begin
                  walk_now = PED && (m_pend || ped_req);
                  nph = walk_now ? 6 : 0;
               end else if (m_phase == 6) nph = 0;
               else nph = m_phase + 1;
            end else begin
               nel = m_elapsed + 1;
            end
         end
         if (walk_now) m_pend <= 1'b0;
         else if (PED && ped_req && m_phase != 6) m_pend <= 1'b1;
         m_phase   <= nph;
         m_elapsed <= nel;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("ns_light", ns_light, m_phase == 0 ? 3'b001 : m_phase == 1 ? 3'b010 : 3'b100);
         chk("ew_light", ew_light, m_phase == 3 ? 3'b001 : m_phase == 4 ? 3'b010 : 3'b100);
         chk("ped_walk", ped_walk, m_phase == 6);
         chk("phase_left", phase_left, plen(m_phase) - 1 - m_elapsed);
         chk("no_dual_go", (ns_light != 3'b100) && (ew_light != 3'b100), 1'b0);
      end
   end

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); tick = 1'b1;
         @(negedge clk); tick = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   logic [2:0] s_ns [1:28];
   logic [2:0] s_ew [1:28];
   int n_g, n_y, n_ewg;

   initial begin
      // 1: reset and first NS cycle
      @(negedge clk); reset = 1'b0;
      #1;
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_ns", ns_light, 3'b100);
      chk("rst_ew", ew_light, 3'b100);
      chk("rst_pl", phase_left, 0);
      ticks(1);
      chk("t1_ns_green", ns_light, 3'b001);
      chk("t1_pl3", phase_left, 3);
      ticks(3);
      chk("t1_still_green", ns_light, 3'b001);
      chk("t1_pl0", phase_left, 0);
      ticks(1);
      chk("t1_ns_yellow", ns_light, 3'b010);
      ticks(1);
      chk("t1_yellow2", ns_light, 3'b010);
      ticks(1);
      chk("t1_allred_ns", ns_light, 3'b100);
      chk("t1_allred_ew", ew_light, 3'b100);

      // 2: two full periods land back on ALL_RED_A
      ticks(28);
      chk("t2_period_ns", ns_light, 3'b100);
      chk("t2_period_ew", ew_light, 3'b100);
      ticks(1);
      chk("t2_ew_green", ew_light, 3'b001);
      chk("t2_ew_pl3", phase_left, 3);
      ticks(1);
      chk("t2_ew_pl2", phase_left, 2);

      // 4: asynchronous reset mid EW_GREEN
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("t4_ns", ns_light, 3'b100);
      chk("t4_ew", ew_light, 3'b100);
      chk("t4_pl", phase_left, 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      ticks(1);
      chk("t4_resume_ns_green", ns_light, 3'b001);

      // 3: tick tied high, durations in clocks
      do_reset();
      tick = 1'b1;
      for (int k = 1; k <= 28; k++) begin
         @(negedge clk);
         s_ns[k] = ns_light;
         s_ew[k] = ew_light;
      end
      tick = 1'b0;
      n_g = 0; n_y = 0; n_ewg = 0;
      for (int k = 1; k <= 14; k++) begin
         if (s_ns[k] == 3'b001) n_g++;
         if (s_ns[k] == 3'b010) n_y++;
         if (s_ew[k] == 3'b001) n_ewg++;
      end
      chk("t3_green_clks", n_g, 4);
      chk("t3_yellow_clks", n_y, 2);
      chk("t3_ew_green_clks", n_ewg, 4);
      chk("t3_first_green", s_ns[1], 3'b001);
      chk("t3_allred_a", s_ns[7], 3'b100);
      chk("t3_ew_start", s_ew[8], 3'b001);
      chk("t3_period14", s_ns[15], 3'b001);

      // 5: pedestrian behaviour
      do_reset();
      ticks(1);
      @(negedge clk); ped_req = 1'b1;
      @(negedge clk); ped_req = 1'b0;
      ticks(14);
`ifdef PED_WALK_EN
      chk("t5_walk_on", ped_walk, 1'b1);
      chk("t5_walk_ns_r", ns_light, 3'b100);
      chk("t5_walk_ew_r", ew_light, 3'b100);
      @(negedge clk); ped_req = 1'b1;
      @(negedge clk); ped_req = 1'b0;
      ticks(3);
      chk("t5_after_walk", ns_light, 3'b001);
      chk("t5_walk_off", ped_walk, 1'b0);
      ticks(14);
      chk("t5_no_second_walk", ped_walk, 1'b0);
      chk("t5_no_second_ns", ns_light, 3'b001);
`else
      chk("t5_off_no_walk", ped_walk, 1'b0);
      chk("t5_off_ns_green", ns_light, 3'b001);
`endif
      ticks(13);
      chk("t5_at_allred_b", ew_light, 3'b100);
      @(negedge clk); tick = 1'b1; ped_req = 1'b1;
      @(negedge clk); tick = 1'b0; ped_req = 1'b0;
      @(negedge clk);
`ifdef PED_WALK_EN
      chk("t5_coinc_walk", ped_walk, 1'b1);
`else
      chk("t5_coinc_off_ns", ns_light, 3'b001);
      chk("t5_coinc_off_walk", ped_walk, 1'b0);
`endif
      ticks(2);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
